shift_right_seq: RTL and testbench

Sequential lane-shift engine that sits upstream of the combinational 50-bit lane shifter stage. It accepts a word and an arbitrary lane shift count of 0..10. It splits the shift into legal steps of at most 4 lanes and applies each step through one registered combinational pass per cycle. Results are presented on a valid/ready output, so downstream logic only ever sees fully shifted words.

---
 rtl/shift_pkg.sv | 36 +++
 rtl/shift_lane_step.sv | 24 ++
 rtl/shift_right_seq.sv | 126 ++++++++++++
 tb/tb_shift_right_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// sequential lane-shift engine.
package shift_pkg;

    localparam int LANE_W   = 5;
    localparam int LANES    = 10;
    localparam int MAX_STEP = 4;
    localparam int DATA_W   = LANE_W * LANES;
    localparam int SHIFT_W  = 4;
    localparam int STEP_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Clamp a requested shift to the word length; larger shifts clear the word.
    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] req);
        if (req > SHIFT_W'(LANES)) begin
            return SHIFT_W'(LANES);
        end else begin
            return req;
        end
    endfunction

    // Largest legal single-cycle step for the lanes still to be shifted.
    function automatic logic [STEP_W-1:0] step_of(input logic [SHIFT_W-1:0] rem);
        if (rem > SHIFT_W'(MAX_STEP)) begin
            return STEP_W'(MAX_STEP);
        end else begin
            return rem[STEP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/shift_lane_step.sv
// One combinational pass of the lane shifter: moves every lane right by
// 'step' lanes and writes 'fill' into each vacated upper lane.
module shift_lane_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [STEP_W-1:0] step,
    input  logic [LANE_W-1:0] fill,
    output logic [DATA_W-1:0] result
);

    // Lane k takes lane k+step, or the fill value once past the top lane.
    always_comb begin
        result = '0;
        for (int k = 0; k < LANES; k++) begin
            if ((k + int'(step)) < LANES) begin
                result[k*LANE_W +: LANE_W] = data[(k + int'(step))*LANE_W +: LANE_W];
            end else begin
                result[k*LANE_W +: LANE_W] = fill;
            end
        end
    end

endmodule

// File: rtl/shift_right_seq.sv
// Sequential lane-shift engine: accepts a word and a shift count, applies the
// shift in steps of at most MAX_STEP lanes per cycle, and presents the fully
// shifted word on a valid/ready output.
module shift_right_seq
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [LANE_W-1:0] in_fill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              busy
);

    state_t              state_r;
    state_t              state_s;
    logic [SHIFT_W-1:0]  remaining_r;
    logic [DATA_W-1:0]   data_r;
    logic [LANE_W-1:0]   fill_r;
    logic                sat_r;
    logic                ready_r;
    logic                busy_r;
    logic                valid_r;

    logic                accept_s;
    logic [SHIFT_W-1:0]  req_shift_s;
    logic [STEP_W-1:0]   step_s;
    logic [SHIFT_W-1:0]  rem_next_s;
    logic [DATA_W-1:0]   shifted_s;

    assign accept_s    = (state_r == IDLE) && ready_r && in_valid;
    assign req_shift_s = clamp_shift(in_shift);
    assign step_s      = step_of(remaining_r);
    assign rem_next_s  = remaining_r - SHIFT_W'(step_s);

    shift_lane_step u_step (
        .data   (data_r),
        .step   (step_s),
        .fill   (fill_r),
        .result (shifted_s)
    );

    // Next-state decode for the IDLE -> SHIFT -> DONE request sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_shift_s == {SHIFT_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_next_s == {SHIFT_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake decodes; reset aborts any request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            remaining_r <= {SHIFT_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            fill_r      <= {LANE_W{1'b0}};
            sat_r       <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
            busy_r  <= (state_s != IDLE);
            valid_r <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        data_r      <= in_data;
                        fill_r      <= in_fill;
                        remaining_r <= req_shift_s;
                        sat_r       <= (in_shift > SHIFT_W'(LANES));
                    end
                end
                SHIFT: begin
                    data_r      <= shifted_s;
                    remaining_r <= rem_next_s;
                end
                default: begin
                    data_r <= data_r;
                end
            endcase
        end
    end

    assign in_ready  = ready_r;
    assign busy      = busy_r;
    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_sat   = sat_r;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: the driver pushes hand-computed
// results on accept, a monitor compares whenever out_valid is presented.
`timescale 1ns/1ps
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [49:0] in_data;
    logic [3:0]  in_shift;
    logic [4:0]  in_fill;
    logic        out_valid;
    logic        out_ready;
    logic [49:0] out_data;
    logic        out_sat;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic [49:0] exp_data_q[$];
    logic        exp_sat_q[$];
    int          exp_lat_q[$];
    longint      acc_q[$];
    bit          seen = 1'b0;

    localparam logic [49:0] DATA = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

    shift_right_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_fill   (in_fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got %h expected no output", out_data);
                end else begin
                    if (!seen) begin
                        check("latency", 64'(($time - acc_q[0] + 3) / 10), 64'(exp_lat_q[0]));
                        seen = 1'b1;
                    end
                    check("out_data", 64'(out_data), 64'(exp_data_q[0]));
                    check("out_sat", 64'(out_sat), 64'(exp_sat_q[0]));
                    if (out_ready) begin
                        void'(exp_data_q.pop_front());
                        void'(exp_sat_q.pop_front());
                        void'(exp_lat_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [49:0] d, input logic [3:0] s, input logic [4:0] f,
                        input logic [49:0] ed, input logic es, input int el, input bit track);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        in_fill  = f;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (track) begin
                exp_data_q.push_back(ed);
                exp_sat_q.push_back(es);
                exp_lat_q.push_back(el);
                acc_q.push_back(longint'($time));
            end
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_data_q.size() != 0 || !in_ready) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_data_q.size() != 0) begin
            check("drain_timeout", 64'(exp_data_q.size()), 64'd0);
        end
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_fill   = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);

        send(DATA, 4'd3, 5'h1F, {5'h1F, 5'h1F, 5'h1F, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3}, 1'b0, 2, 1'b1);
        send(DATA, 4'd0, 5'h1F, DATA, 1'b0, 1, 1'b1);
        send(DATA, 4'd10, 5'h0A, {10{5'h0A}}, 1'b0, 4, 1'b1);
        send(DATA, 4'd15, 5'h11, {10{5'h11}}, 1'b1, 4, 1'b1);
        send(DATA, 4'd4, 5'h01, {5'h01, 5'h01, 5'h01, 5'h01, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4}, 1'b0, 2, 1'b1);
        send(DATA, 4'd5, 5'h00, {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 3, 1'b1);
        send(DATA, 4'd11, 5'h15, {10{5'h15}}, 1'b1, 4, 1'b1);
        wait_drain();

        // Backpressure: result held through a 5-cycle stall, extra request refused.
        @(negedge clk);
        out_ready = 1'b0;
        send(DATA, 4'd6, 5'h03, {5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'd9, 5'd8, 5'd7, 5'd6}, 1'b0, 3, 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("stall_reach_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = ~DATA;
            in_shift = 4'd2;
            in_fill  = 5'h1C;
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data", 64'(out_data),
                  64'({5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'd9, 5'd8, 5'd7, 5'd6}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        wait_drain();

        // Reset during SHIFT aborts the request with no output.
        send(DATA, 4'd9, 5'h07, {10{5'h07}}, 1'b0, 4, 1'b0);
        @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_release_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_output", 64'(out_valid), 64'd0);
        end
        send(DATA, 4'd1, 5'h1E, {5'h1E, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0, 2, 1'b1);
        wait_drain();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
